rlwe_imem_loader: RTL and testbench

- Parametrised successor to the core's FIFO-to-instruction-memory path.
- On command, moves a programmed number of words from the host instruction FIFO into an internal sram_1r1w instruction memory, then records the program length.
- Provides a 1-cycle-latency fetch port for the RLWE core sequencer, with out-of-range detection.
- Sits between the host FIFO and the rlwecore control unit.

---
 rtl/rlwe_imem_loader_if.sv | 43 ++++
 rtl/rlwe_imem_loader.sv | 162 ++++++++++++++++
 tb/tb_rlwe_imem_loader.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rlwe_imem_loader_if.sv
// Host-FIFO, load-control and fetch-port signals of the instruction-memory loader.
// The checksum wire exists only when RLWE_IMEM_CHECKSUM_EN is defined.
interface rlwe_imem_loader_if #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 1024
);
   localparam int AW = $clog2(DEPTH);

   logic             empty;
   logic [WIDTH-1:0] value_o;
   logic             dequeue_en;
   logic             load_start;
   logic [AW:0]      load_len;
   logic             load_abort;
   logic             busy;
   logic             load_done;
   logic             load_err;
   logic [AW:0]      prog_len;
   logic             fetch_en;
   logic [AW-1:0]    fetch_addr;
   logic             fetch_valid;
   logic [WIDTH-1:0] fetch_data;
   logic             fetch_oob;
`ifdef RLWE_IMEM_CHECKSUM_EN
   logic [WIDTH-1:0] checksum;
`endif

   modport master (
`ifdef RLWE_IMEM_CHECKSUM_EN
      input  checksum,
`endif
      output empty, value_o, load_start, load_len, load_abort, fetch_en, fetch_addr,
      input  dequeue_en, busy, load_done, load_err, prog_len, fetch_valid, fetch_data, fetch_oob
   );

   modport slave (
`ifdef RLWE_IMEM_CHECKSUM_EN
      output checksum,
`endif
      input  empty, value_o, load_start, load_len, load_abort, fetch_en, fetch_addr,
      output dequeue_en, busy, load_done, load_err, prog_len, fetch_valid, fetch_data, fetch_oob
   );
endinterface

// File: rtl/rlwe_imem_loader.sv
// Copies load_len FWFT-FIFO words into instruction SRAM (an empty FIFO stalls the load, no timeout)
// and serves 1-cycle-latency fetches outside LOAD; RLWE_IMEM_CHECKSUM_EN adds a per-load XOR checksum.
module sram_1r1w #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 1024,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             write_en,
   input  logic [AW-1:0]    write_addr,
   input  logic [WIDTH-1:0] write_data,
   input  logic             read_en,
   input  logic [AW-1:0]    read_addr,
   output logic [WIDTH-1:0] read_data
);
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (write_en) begin
         mem[write_addr] <= write_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         read_data <= '0;
      end else if (read_en) begin
         read_data <= mem[read_addr];
      end
   end
endmodule

module rlwe_imem_loader #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 1024
) (
   input logic              clk,
   input logic              rst_n,
   rlwe_imem_loader_if.slave bus
);
   localparam int          AW        = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_LEN = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t           state, state_nxt;
   logic [AW:0]      len, cnt, cnt_inc, prog_len;
   logic [AW-1:0]    wr_addr;
   logic             start_ok, start_bad, abort, pop, last_pop, fetch_acc;
   logic             load_done, load_err, fetch_valid, fetch_oob;
   logic [WIDTH-1:0] rd_data;

   assign start_ok  = (state == IDLE) && bus.load_start && (bus.load_len <= DEPTH_LEN);
   assign start_bad = (state == IDLE) && bus.load_start && (bus.load_len >  DEPTH_LEN);
   assign abort     = (state == LOAD) && bus.load_abort;
   assign cnt_inc   = cnt + (AW+1)'(1);
   assign last_pop  = pop && (cnt_inc == len);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (start_ok) begin
               state_nxt = (bus.load_len == '0) ? DONE : LOAD;
            end
         end
         LOAD: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (last_pop) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Abort wins over a pending pop so no word is lost from the FIFO on the abort cycle.
   always_comb begin
      pop            = (state == LOAD) && !bus.empty && !bus.load_abort;
      fetch_acc      = bus.fetch_en && (state != LOAD);
      bus.dequeue_en = pop;
      bus.busy       = (state == LOAD);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len         <= '0;
         cnt         <= '0;
         wr_addr     <= '0;
         prog_len    <= '0;
         load_done   <= 1'b0;
         load_err    <= 1'b0;
         fetch_valid <= 1'b0;
         fetch_oob   <= 1'b0;
      end else begin
         load_done   <= (state_nxt == DONE);
         load_err    <= start_bad;
         fetch_valid <= fetch_acc;
         fetch_oob   <= fetch_acc && ({1'b0, bus.fetch_addr} >= prog_len);
         if (start_ok) begin
            len      <= bus.load_len;
            cnt      <= '0;
            wr_addr  <= '0;
            prog_len <= '0;
         end else if (abort) begin
            prog_len <= '0;
         end else if (pop) begin
            cnt     <= cnt_inc;
            wr_addr <= wr_addr + AW'(1);
            if (last_pop) begin
               prog_len <= len;
            end
         end
      end
   end

`ifdef RLWE_IMEM_CHECKSUM_EN
   logic [WIDTH-1:0] checksum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         checksum <= '0;
      end else if (start_ok || abort) begin
         checksum <= '0;
      end else if (pop) begin
         checksum <= checksum ^ bus.value_o;
      end
   end

   assign bus.checksum = checksum;
`endif

   // Read and write never collide: fetches are refused for the whole of LOAD.
   sram_1r1w #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_imem (
      .clk        (clk),
      .rst_n      (rst_n),
      .write_en   (pop),
      .write_addr (wr_addr),
      .write_data (bus.value_o),
      .read_en    (fetch_acc),
      .read_addr  (bus.fetch_addr),
      .read_data  (rd_data)
   );

   assign bus.load_done   = load_done;
   assign bus.load_err    = load_err;
   assign bus.prog_len    = prog_len;
   assign bus.fetch_valid = fetch_valid;
   assign bus.fetch_oob   = fetch_oob;
   assign bus.fetch_data  = fetch_oob ? '0 : rd_data;
endmodule

// File: tb/tb_rlwe_imem_loader.sv
// Bench for rlwe_imem_loader: table of directed loads, hand sequences for fetch-during-load and async reset,
// then random loads/fetches against a word-level memory model (checksum checks when RLWE_IMEM_CHECKSUM_EN).
module tb_rlwe_imem_loader;
   localparam int W  = 64;
   localparam int D  = 16;
   localparam int AW = $clog2(D);

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   rlwe_imem_loader_if #(.WIDTH(W), .DEPTH(D)) bus ();

   rlwe_imem_loader #(.WIDTH(W), .DEPTH(D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          n_chk  = 0;
   int          n_fail = 0;
   int          npops  = 0;
   bit          stall  = 1'b0;
   logic [63:0] fifo_q [$];
   logic [63:0] mem_m [D];
   int          plen_m = 0;
   logic [63:0] cks_m  = '0;

   typedef struct {
      int          len;
      int          mode;
      int          abort_after;
      logic [63:0] base;
      logic [63:0] step;
      int          plen;
      int          faddr;
      bit          oob;
      logic [63:0] data;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_fifo();
      bus.empty   = stall || (fifo_q.size() == 0);
      bus.value_o = (fifo_q.size() != 0) ? fifo_q[0] : '0;
   endtask

   // The FIFO head advances only when the DUT's pop was high just before the edge.
   task automatic tick();
      logic        p;
      logic [63:0] tmp;
      #1;
      p = bus.dequeue_en;
      @(posedge clk);
      #1;
      if (p) begin
         if (fifo_q.size() != 0) tmp = fifo_q.pop_front();
         npops++;
      end
      drive_fifo();
   endtask

   task automatic check_fetch(input int addr, input string tag);
      bit exp_oob;
      exp_oob = (addr >= plen_m);
      chk({tag, "_valid"}, bus.fetch_valid, 1);
      chk({tag, "_oob"}, bus.fetch_oob, exp_oob);
      chk({tag, "_data"}, bus.fetch_data, exp_oob ? 64'h0 : mem_m[addr]);
   endtask

   task automatic run_load(input int len, input int mode, input int abort_after,
                           input logic [63:0] base, input logic [63:0] step);
      logic [63:0] words [$];
      logic [63:0] cks;
      int          p0, cyc, n;
      bit          aborted;
      fifo_q.delete();
      for (int i = 0; i < len && i <= D; i++) words.push_back(base + step * 64'(i));
      foreach (words[i]) fifo_q.push_back(words[i]);
      stall = 1'b0;
      drive_fifo();
      bus.load_start = 1'b1;
      bus.load_len   = len[AW:0];
      p0 = npops;
      tick();
      bus.load_start = 1'b0;
      bus.load_len   = '0;
      if (len > D) begin
         chk("err_pulse", bus.load_err, 1);
         chk("err_busy", bus.busy, 0);
         chk("err_plen", bus.prog_len, plen_m);
         tick();
         chk("err_clear", bus.load_err, 0);
         chk("err_pops", npops - p0, 0);
         return;
      end
      if (len == 0) begin
         chk("zero_done", bus.load_done, 1);
         chk("zero_busy", bus.busy, 0);
         chk("zero_plen", bus.prog_len, 0);
         plen_m = 0;
         cks_m  = '0;
`ifdef RLWE_IMEM_CHECKSUM_EN
         chk("zero_cks", bus.checksum, 0);
`endif
         tick();
         chk("zero_done_clr", bus.load_done, 0);
         return;
      end
      chk("start_busy", bus.busy, 1);
      chk("start_plen", bus.prog_len, 0);
      cyc = 0;
      aborted = 1'b0;
      while (bus.busy && cyc < 8 * D + 20) begin
         case (mode)
            1:       stall = (cyc % 2 == 0);
            2:       stall = ($urandom_range(0, 2) == 0);
            default: stall = 1'b0;
         endcase
         drive_fifo();
         bus.load_abort = (abort_after >= 0) && (npops - p0 == abort_after);
         #1;
         chk("deq", bus.dequeue_en, !bus.empty && !bus.load_abort);
         aborted = bus.load_abort;
         tick();
         bus.load_abort = 1'b0;
         cyc++;
         if (aborted) break;
      end
      if (bus.busy) begin
         n_chk++;
         n_fail++;
         $display("FAIL load_timeout: busy still 1 after %0d cycles, expected load to finish", cyc);
      end
      n   = npops - p0;
      cks = '0;
      for (int k = 0; k < n && k < words.size(); k++) begin
         mem_m[k] = words[k];
         cks ^= words[k];
      end
      if (aborted) begin
         chk("abort_busy", bus.busy, 0);
         chk("abort_plen", bus.prog_len, 0);
         chk("abort_done", bus.load_done, 0);
         chk("abort_pops", n, abort_after);
         plen_m = 0;
         cks_m  = '0;
`ifdef RLWE_IMEM_CHECKSUM_EN
         chk("abort_cks", bus.checksum, 0);
`endif
         tick();
         chk("abort_nopop", npops - p0, abort_after);
      end else begin
         chk("done_pulse", bus.load_done, 1);
         chk("done_plen", bus.prog_len, len);
         chk("done_pops", n, len);
         plen_m = len;
         cks_m  = cks;
`ifdef RLWE_IMEM_CHECKSUM_EN
         chk("done_cks", bus.checksum, cks_m);
`endif
         tick();
         chk("done_clr", bus.load_done, 0);
         chk("idle_busy", bus.busy, 0);
      end
   endtask

   task automatic fetch_burst(input int n);
      int a;
      for (int k = 0; k < n; k++) begin
         a = $urandom_range(0, D - 1);
         bus.fetch_en   = 1'b1;
         bus.fetch_addr = a[AW-1:0];
         tick();
         check_fetch(a, "rnd_fetch");
      end
      bus.fetch_en = 1'b0;
      tick();
      chk("fetch_idle", bus.fetch_valid, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl [8];
      logic [63:0] stp;
      bit          prev_busy;
      int          ln, md, ab;

      rst_n = 1'b0;
      bus.load_start = 1'b0; bus.load_len = '0; bus.load_abort = 1'b0;
      bus.fetch_en = 1'b0;   bus.fetch_addr = '0;
      drive_fifo();
      #12;
      chk("rst_busy", bus.busy, 0);
      chk("rst_deq", bus.dequeue_en, 0);
      chk("rst_done", bus.load_done, 0);
      chk("rst_err", bus.load_err, 0);
      chk("rst_plen", bus.prog_len, 0);
      chk("rst_fvalid", bus.fetch_valid, 0);
      chk("rst_foob", bus.fetch_oob, 0);
      chk("rst_fdata", bus.fetch_data, 0);
`ifdef RLWE_IMEM_CHECKSUM_EN
      chk("rst_cks", bus.checksum, 0);
`endif
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      tbl[0] = '{4,     0, -1, 64'h11,  64'h11,  4, 2,     1'b0, 64'h33};
      tbl[1] = '{3,     1, -1, 64'h100, 64'h100, 3, 2,     1'b0, 64'h300};
      tbl[2] = '{D,     0, -1, 64'h0,   64'h1,   D, D - 1, 1'b0, 64'(D - 1)};
      tbl[3] = '{D + 1, 0, -1, 64'h0,   64'h0,   D, 0,     1'b0, 64'h0};
      tbl[4] = '{0,     0, -1, 64'h0,   64'h0,   0, 0,     1'b1, 64'h0};
      tbl[5] = '{5,     0,  2, 64'h55,  64'h1,   0, 0,     1'b1, 64'h0};
      tbl[6] = '{4,     2, -1, 64'hA0,  64'h1,   4, 5,     1'b1, 64'h0};
      tbl[7] = '{4,     2, -1, 64'hA0,  64'h1,   4, 3,     1'b0, 64'hA3};
      for (int v = 0; v < 8; v++) begin
         run_load(tbl[v].len, tbl[v].mode, tbl[v].abort_after, tbl[v].base, tbl[v].step);
         chk("tbl_plen", bus.prog_len, tbl[v].plen);
         bus.fetch_en   = 1'b1;
         bus.fetch_addr = tbl[v].faddr[AW-1:0];
         tick();
         bus.fetch_en = 1'b0;
         chk("tbl_fvalid", bus.fetch_valid, 1);
         chk("tbl_foob", bus.fetch_oob, tbl[v].oob);
         chk("tbl_fdata", bus.fetch_data, tbl[v].data);
         tick();
      end

      // Fetch held high across a load: results only for cycles that were not in LOAD.
      fifo_q.delete();
      for (int i = 0; i < 3; i++) fifo_q.push_back(64'h700 + 64'(i));
      stall = 1'b0;
      drive_fifo();
      bus.fetch_en   = 1'b1;
      bus.fetch_addr = '0;
      bus.load_start = 1'b1;
      bus.load_len   = 3;
      prev_busy = bus.busy;
      ln = npops;
      for (int c = 0; c < 7; c++) begin
         tick();
         bus.load_start = 1'b0;
         chk("fdl_valid", bus.fetch_valid, !prev_busy);
         prev_busy = bus.busy;
      end
      chk("fdl_pops", npops - ln, 3);
      for (int i = 0; i < 3; i++) mem_m[i] = 64'h700 + 64'(i);
      plen_m = 3;
      check_fetch(0, "fdl_after");
      bus.fetch_en = 1'b0;
      tick();

      // Checksum of a two-word load, then asynchronous reset in the middle of a load.
      stp = 64'h0F - 64'hF0;
      run_load(2, 0, -1, 64'hF0, stp);
`ifdef RLWE_IMEM_CHECKSUM_EN
      chk("cks_ff", bus.checksum, 64'hFF);
`endif
      bus.fetch_en = 1'b1;
      bus.fetch_addr = '0;
      tick();
      bus.fetch_en = 1'b0;
      check_fetch(0, "pre_arst_fetch");
      fifo_q.delete();
      fifo_q.push_back(64'hAA); fifo_q.push_back(64'hBB); fifo_q.push_back(64'hCC);
      drive_fifo();
      bus.load_start = 1'b1;
      bus.load_len   = 3;
      tick();
      bus.load_start = 1'b0;
      tick();
      mem_m[0] = 64'hAA;
      chk("pre_arst_busy", bus.busy, 1);
      chk("pre_arst_fdata", bus.fetch_data, 64'hF0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", bus.busy, 0);
      chk("arst_deq", bus.dequeue_en, 0);
      chk("arst_plen", bus.prog_len, 0);
      chk("arst_done", bus.load_done, 0);
      chk("arst_fvalid", bus.fetch_valid, 0);
      chk("arst_fdata", bus.fetch_data, 0);
`ifdef RLWE_IMEM_CHECKSUM_EN
      chk("arst_cks", bus.checksum, 0);
`endif
      #2;
      rst_n = 1'b1;
      fifo_q.delete();
      drive_fifo();
      plen_m = 0;
      cks_m  = '0;
      tick();

      for (int r = 0; r < 40; r++) begin
         if ($urandom_range(0, 9) == 0)      ln = $urandom_range(D + 1, D + 2);
         else if ($urandom_range(0, 5) == 0) ln = 0;
         else                                ln = $urandom_range(1, D);
         md = $urandom_range(0, 2);
         ab = (ln > 1 && ln <= D && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, ln - 1)) : -1;
         run_load(ln, md, ab, {$urandom, $urandom}, {$urandom, $urandom});
         fetch_burst($urandom_range(1, 6));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
